mux_nx1_rr: RTL and testbench

//   Parametrised N:1 data multiplexer with a registered output and valid/ready handshake on every port.

---
 rtl/mux_nx1_rr.sv | 85 ++++++++
 tb/tb_mux_nx1_rr.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_rr.sv
// N:1 valid/ready funnel with a one-entry registered output stage.
// Arbitration is round-robin (RR_MODE=1) or fixed lowest-index priority (RR_MODE=0).
module mux_nx1_rr #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int RR_MODE = 1,
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CW-1:0]            out_ch,
  input  logic                     out_ready
);

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [CW-1:0]     out_ch_reg;
  logic [CW-1:0]     ptr_reg;

  logic              can_load;
  logic              load;
  logic              win_found;
  logic [CW-1:0]     win_idx;
  logic [CW-1:0]     search_base;
  logic [CW:0]       cand;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*DATA_W +: DATA_W];
      assign in_ready[gi] = !rst && load && (win_idx == CW'(gi));
    end
  endgenerate

  assign can_load    = !out_valid_reg || out_ready;
  assign load        = win_found && can_load;
  assign search_base = (RR_MODE != 0) ? ptr_reg : '0;

  // Scan channels starting at the pointer, wrapping modulo NUM_CH; first valid wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, search_base} + (CW+1)'(k);
      if (cand >= (CW+1)'(NUM_CH)) begin
        cand = cand - (CW+1)'(NUM_CH);
      end
      if (!win_found && in_valid[cand[CW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      ptr_reg       <= '0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= ch_data[win_idx];
      out_ch_reg    <= win_idx;
      if (RR_MODE != 0) begin
        ptr_reg <= (win_idx == CW'(NUM_CH-1)) ? '0 : win_idx + 1'b1;
      end
    end else if (out_ready) begin
      // Drained with nothing to refill: data/channel keep their last value.
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: a round-robin and a fixed-priority instance share stimulus
// and are compared against a distance-based arbitration model.
module tb_mux_nx1_rr;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_ready;

  logic [NUM_CH-1:0] rr_in_ready, fp_in_ready;
  logic              rr_out_valid, fp_out_valid;
  logic [DATA_W-1:0] rr_out_data, fp_out_data;
  logic [1:0]        rr_out_ch, fp_out_ch;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state, index 1 = round-robin instance, 0 = fixed-priority instance.
  logic       m_valid [2];
  logic [7:0] m_data  [2];
  int         m_ch    [2];
  int         m_ptr   [2];

  always #5 clk = ~clk;

  mux_nx1_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RR_MODE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_ch(rr_out_ch), .out_ready(out_ready)
  );

  mux_nx1_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_ch(fp_out_ch), .out_ready(out_ready)
  );

  // Winner = valid channel closest to the pointer going upward (RR), or lowest index (FP).
  function automatic int model_winner(int mode);
    int best  = -1;
    int bestd = NUM_CH;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_valid[c]) begin
        int d = (mode != 0) ? (c - m_ptr[mode] + NUM_CH) % NUM_CH : c;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_ready(int mode);
    int w = model_winner(mode);
    logic [NUM_CH-1:0] r = '0;
    if (w >= 0 && (!m_valid[mode] || out_ready) && !rst) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0; m_data[m] = 8'h00; m_ch[m] = 0; m_ptr[m] = 0;
    end
  endtask

  // Advance the model with the current inputs, then clock the DUTs and settle.
  task automatic tick();
    for (int m = 0; m < 2; m++) begin
      int w = model_winner(m);
      if (w >= 0 && (!m_valid[m] || out_ready)) begin
        m_valid[m] = 1'b1;
        m_data[m]  = in_data[w*DATA_W +: DATA_W];
        m_ch[m]    = w;
        if (m == 1) m_ptr[m] = (w + 1) % NUM_CH;
      end else if (out_ready) begin
        m_valid[m] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    model_reset();
    @(posedge clk); #2;
    n_checks++;
    if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h00 || rr_out_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h ch=%0d, want v=0 d=00 ch=0", rr_out_valid, rr_out_data, rr_out_ch);
    end
    n_checks++;
    if (rr_in_ready !== 4'b0000 || fp_in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_in_ready: got rr=%b fp=%b, want 0000", rr_in_ready, fp_in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Fill the output register and hold it, then reset asynchronously mid-cycle.
    in_valid = 4'b0001; out_ready = 1'b0;
    tick();
    n_checks++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 8'h11) begin
      n_fail++;
      $display("FAIL reset_prefill: got v=%b d=%h, want v=1 d=11", rr_out_valid, rr_out_data);
    end
    #2; rst = 1'b1; #1;
    model_reset();
    n_checks++;
    if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h00 || rr_out_ch !== 2'd0 || rr_in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b d=%h ch=%0d rdy=%b, want 0 00 0 0000",
               rr_out_valid, rr_out_data, rr_out_ch, rr_in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = '0; out_ready = 1'b1;
  endtask

  task automatic test_single();
    hard_reset();
    in_valid = 4'b0100; out_ready = 1'b1;
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    #1;
    n_checks++;
    if (rr_in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_in_ready: got %b, want 0100", rr_in_ready);
    end
    tick();
    in_valid = '0;
    n_checks++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 8'hA5 || rr_out_ch !== 2'd2) begin
      n_fail++;
      $display("FAIL single_out: got v=%b d=%h ch=%0d, want v=1 d=a5 ch=2", rr_out_valid, rr_out_data, rr_out_ch);
    end
  endtask

  task automatic test_rr_fairness();
    hard_reset();
    in_valid = 4'b1111; out_ready = 1'b1;
    set_data(8'd0, 8'd1, 8'd2, 8'd3);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (rr_out_valid !== 1'b1 || rr_out_ch !== 2'(i % NUM_CH) || rr_out_data !== 8'(i % NUM_CH)) begin
        n_fail++;
        $display("FAIL rr_fair[%0d]: got v=%b ch=%0d d=%h, want v=1 ch=%0d", i, rr_out_valid, rr_out_ch, rr_out_data, i % NUM_CH);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_fixed_priority();
    hard_reset();
    in_valid = 4'b1010; out_ready = 1'b1;
    set_data(8'h00, 8'h5A, 8'h00, 8'hC3);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (fp_out_valid !== 1'b1 || fp_out_ch !== 2'd1 || fp_out_data !== 8'h5A) begin
        n_fail++;
        $display("FAIL fixed_prio[%0d]: got v=%b ch=%0d d=%h, want v=1 ch=1 d=5a", i, fp_out_valid, fp_out_ch, fp_out_data);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    hard_reset();
    in_valid = 4'b0001; out_ready = 1'b0;
    set_data(8'h3C, 8'h77, 8'h88, 8'h00);
    tick();
    in_valid = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (rr_in_ready !== 4'b0000 || rr_out_valid !== 1'b1 || rr_out_data !== 8'h3C || rr_out_ch !== 2'd0) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got rdy=%b v=%b d=%h ch=%0d, want 0000 1 3c 0",
                 i, rr_in_ready, rr_out_valid, rr_out_data, rr_out_ch);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (rr_in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b, want 0010", rr_in_ready);
    end
    tick();
    n_checks++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 8'h77 || rr_out_ch !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_release_out: got v=%b d=%h ch=%0d, want 1 77 1", rr_out_valid, rr_out_data, rr_out_ch);
    end
    in_valid = '0;
  endtask

  task automatic test_wrap();
    hard_reset();
    out_ready = 1'b1;
    set_data(8'hD0, 8'h00, 8'hD2, 8'hD3);
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b1001;
    #1;
    n_checks++;
    if (rr_in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_ptr3: got rdy=%b, want 1000", rr_in_ready);
    end
    tick();
    n_checks++;
    if (rr_out_ch !== 2'd3 || rr_out_data !== 8'hD3) begin
      n_fail++;
      $display("FAIL wrap_ch3: got ch=%0d d=%h, want 3 d3", rr_out_ch, rr_out_data);
    end
    n_checks++;
    if (rr_in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_ptr0: got rdy=%b, want 0001", rr_in_ready);
    end
    tick();
    n_checks++;
    if (rr_out_ch !== 2'd0 || rr_out_data !== 8'hD0) begin
      n_fail++;
      $display("FAIL wrap_ch0: got ch=%0d d=%h, want 0 d0", rr_out_ch, rr_out_data);
    end
    in_valid = 4'b1110;
    #1;
    n_checks++;
    if (rr_in_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_ptr1: got rdy=%b, want 0010", rr_in_ready);
    end
    in_valid = '0;
  endtask

  task automatic test_random();
    hard_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (rr_in_ready !== exp_ready(1) || fp_in_ready !== exp_ready(0)) begin
        n_fail++;
        $display("FAIL random_ready[%0d]: got rr=%b fp=%b, want rr=%b fp=%b",
                 i, rr_in_ready, fp_in_ready, exp_ready(1), exp_ready(0));
      end
      tick();
      n_checks++;
      if (rr_out_valid !== m_valid[1] || rr_out_data !== m_data[1] || rr_out_ch !== 2'(m_ch[1])) begin
        n_fail++;
        $display("FAIL random_rr[%0d]: got v=%b d=%h ch=%0d, want v=%b d=%h ch=%0d",
                 i, rr_out_valid, rr_out_data, rr_out_ch, m_valid[1], m_data[1], m_ch[1]);
      end
      n_checks++;
      if (fp_out_valid !== m_valid[0] || fp_out_data !== m_data[0] || fp_out_ch !== 2'(m_ch[0])) begin
        n_fail++;
        $display("FAIL random_fp[%0d]: got v=%b d=%h ch=%0d, want v=%b d=%h ch=%0d",
                 i, fp_out_valid, fp_out_data, fp_out_ch, m_valid[0], m_data[0], m_ch[0]);
      end
    end
    in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_fairness();
    test_fixed_priority();
    test_backpressure();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
